// File: rtl/konami2_bus_master.sv
// Konami-2 external bus initiator: turns single-byte requests into AS/ADDR/RWb/data
// cycles, generates the CE/CQ quadrature clocks and stretches T3 until DTAC or timeout.
module konami2_bus_master #(
  parameter int          TIMEOUT   = 255,
  parameter logic [7:0]  RDATA_ERR = 8'hFF
) (
  input  logic        CLK12,
  input  logic        RSTn,
  input  logic        REQ,
  input  logic        REQ_RW,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        REQ_ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  RDATA,
  output logic        AS,
  output logic [15:0] ADDR,
  output logic        RWb,
  output logic [7:0]  DOUT,
  output logic        DOE,
  input  logic [7:0]  DIN,
  input  logic        DTAC,
  output logic        CE,
  output logic        CQ
);

  localparam logic [9:0] TIMEOUT_W = 10'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  ph_reg, ph_next;
  logic [9:0]  wc_reg, wc_next;
  logic [15:0] addr_reg;
  logic        rw_reg;
  logic [7:0]  wdata_reg;
  logic [7:0]  rdata_reg;
  logic        done_reg, err_reg;
  logic        ce_reg, cq_reg;
  logic        accept, finish, abort;

  // Requests are only taken at PH==3 so T0 always lines up with PH==0.
  assign accept = (state_reg == IDLE) && (ph_reg == 2'd3) && REQ;

  always_comb begin
    state_next = state_reg;
    ph_next    = ph_reg + 2'd1;
    wc_next    = wc_reg;
    finish     = 1'b0;
    abort      = 1'b0;
    unique case (state_reg)
      IDLE: if (accept) state_next = T0;
      T0:   state_next = T1;
      T1:   state_next = T2;
      T2:   state_next = T3;
      T3: begin
        ph_next = 2'd3;
        if (!DTAC) begin
          finish = 1'b1;
        end else if (wc_reg == TIMEOUT_W) begin
          finish = 1'b1;
          abort  = 1'b1;
        end else begin
          wc_next = wc_reg + 10'd1;
        end
        if (finish) begin
          state_next = IDLE;
          ph_next    = 2'd0;
          wc_next    = 10'd0;
        end
      end
      default: begin
        state_next = IDLE;
        ph_next    = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK12 or negedge RSTn) begin
    if (!RSTn) begin
      state_reg <= IDLE;
      ph_reg    <= 2'd0;
      wc_reg    <= 10'd0;
      addr_reg  <= 16'd0;
      rw_reg    <= 1'b1;
      wdata_reg <= 8'd0;
      rdata_reg <= 8'd0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      ce_reg    <= 1'b0;
      cq_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ph_reg    <= ph_next;
      wc_reg    <= wc_next;
      done_reg  <= finish;
      // CE/CQ are registered from the next phase so they track PH without a decode glitch.
      ce_reg    <= ph_next[1];
      cq_reg    <= ph_next[1] ^ ph_next[0];
      if (accept) begin
        addr_reg  <= REQ_ADDR;
        rw_reg    <= REQ_RW;
        wdata_reg <= REQ_WDATA;
      end
      if (finish) begin
        err_reg <= abort;
        if (rw_reg) rdata_reg <= abort ? RDATA_ERR : DIN;
      end
    end
  end

  assign REQ_ACK = accept;
  assign BUSY    = accept || (state_reg != IDLE);
  assign DONE    = done_reg;
  assign ERR     = err_reg;
  assign RDATA   = rdata_reg;
  assign AS      = (state_reg == T1) || (state_reg == T2) || (state_reg == T3);
  assign ADDR    = addr_reg;
  assign RWb     = (state_reg == IDLE) ? 1'b1 : rw_reg;
  assign DOE     = !rw_reg && ((state_reg == T2) || (state_reg == T3));
  assign DOUT    = DOE ? wdata_reg : 8'd0;
  assign CE      = ce_reg;
  assign CQ      = cq_reg;

endmodule

// File: tb/tb_konami2_bus_master.sv
// Bench for konami2_bus_master: a transaction-timeline model checked every cycle,
// plus directed scenarios with hand-computed latencies and data.
module tb_konami2_bus_master;

  localparam int TO = 4;

  logic        CLK12 = 1'b0;
  logic        RSTn = 1'b0;
  logic        REQ = 1'b0;
  logic        REQ_RW = 1'b0;
  logic [15:0] REQ_ADDR = 16'd0;
  logic [7:0]  REQ_WDATA = 8'd0;
  logic [7:0]  DIN = 8'd0;
  logic        DTAC = 1'b1;
  logic        REQ_ACK, BUSY, DONE, ERR, AS, RWb, DOE, CE, CQ;
  logic [7:0]  RDATA, DOUT;
  logic [15:0] ADDR;

  konami2_bus_master #(.TIMEOUT(TO), .RDATA_ERR(8'hFF)) dut (
    .CLK12(CLK12), .RSTn(RSTn), .REQ(REQ), .REQ_RW(REQ_RW), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_ACK(REQ_ACK), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .RDATA(RDATA), .AS(AS), .ADDR(ADDR), .RWb(RWb), .DOUT(DOUT), .DOE(DOE),
    .DIN(DIN), .DTAC(DTAC), .CE(CE), .CQ(CQ)
  );

  always #5 CLK12 = ~CLK12;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge CLK12) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Stimulus-owned: how many T3 samples see DTAC high for the next transaction.
  int hold_cfg = 0;

  // Timeline model state.
  bit          m_busy = 0;
  int          m_acc = 0, m_s = 0, m_hold = 0, m_idle0 = 0;
  bit          m_rw = 1, m_abort = 0, m_err = 0;
  logic [15:0] m_cap_addr = 0, m_addr = 0;
  logic [7:0]  m_wdata = 0, m_rdata = 0;

  // DUT observations used by the directed checks.
  int ack_cyc = 0, prev_ack_cyc = 0, done_cyc = 0, n_ack = 0, n_done = 0;
  int as_cnt = 0, t3_cnt = 0, req_cyc = 0;

  initial begin : compare
    int k, ph;
    bit e_ack, e_done, e_busy, e_as, e_rwb, e_doe;
    logic [15:0] e_addr;
    forever begin
      @(negedge CLK12);
      if (!RSTn) begin
        m_busy = 0; m_addr = 0; m_rdata = 0; m_err = 0; m_idle0 = cyc + 1;
        DTAC = 1'b0;
        chk("rst_as", AS, 0);     chk("rst_addr", ADDR, 0); chk("rst_rwb", RWb, 1);
        chk("rst_doe", DOE, 0);   chk("rst_dout", DOUT, 0); chk("rst_done", DONE, 0);
        chk("rst_busy", BUSY, 0); chk("rst_ack", REQ_ACK, 0);
        chk("rst_ce", CE, 0);     chk("rst_cq", CQ, 0);
        chk("rst_err", ERR, 0);   chk("rst_rdata", RDATA, 0);
      end else begin
        e_ack = 0; e_done = 0; e_busy = 0; e_as = 0; e_rwb = 1; e_doe = 0;
        e_addr = m_addr; k = 0; ph = 0;
        if (!m_busy) begin
          ph = (cyc - m_idle0) % 4;
          if (REQ && ph == 3) begin
            m_busy = 1; m_acc = cyc; m_rw = REQ_RW; m_cap_addr = REQ_ADDR;
            m_wdata = REQ_WDATA; m_hold = hold_cfg;
            m_s = (hold_cfg > TO) ? TO : hold_cfg;
            m_abort = (hold_cfg > TO);
          end
        end
        if (m_busy) begin
          k = cyc - m_acc;
          if (k == 0)              ph = 3;
          else if (k <= 3)         ph = k - 1;
          else if (k <= 4 + m_s)   ph = 3;
          if (k <= 4 + m_s) begin
            e_ack  = (k == 0);
            e_busy = 1;
            e_as   = (k >= 2);
            e_rwb  = (k >= 1) ? m_rw : 1'b1;
            e_addr = (k >= 1) ? m_cap_addr : m_addr;
            e_doe  = !m_rw && (k >= 3);
          end else begin
            ph = 0; e_done = 1; m_busy = 0; m_idle0 = cyc;
            m_addr = m_cap_addr; e_addr = m_addr;
            m_err = m_abort;
            if (m_rw) m_rdata = m_abort ? 8'hFF : DIN;
          end
        end
        chk("req_ack", REQ_ACK, e_ack); chk("busy", BUSY, e_busy);
        chk("done", DONE, e_done);      chk("as", AS, e_as);
        chk("rwb", RWb, e_rwb);         chk("addr", ADDR, e_addr);
        chk("doe", DOE, e_doe);         chk("dout", DOUT, e_doe ? m_wdata : 8'd0);
        chk("ce", CE, (ph >= 2));       chk("cq", CQ, (ph == 1 || ph == 2));
        chk("err", ERR, m_err);         chk("rdata", RDATA, m_rdata);
        // DTAC is low everywhere except the stretched T3 samples, so early lows must be ignored.
        if (m_busy && k >= 4 && k <= 4 + m_s) DTAC = ((k - 4) < m_hold);
        else DTAC = 1'b0;
        if (REQ_ACK) begin
          prev_ack_cyc = ack_cyc; ack_cyc = cyc; n_ack++; as_cnt = 0; t3_cnt = 0;
        end
        if (AS) as_cnt++;
        if (AS && CE && !CQ) t3_cnt++;
        if (DONE) begin done_cyc = cyc; n_done++; end
      end
    end
  end

  task automatic wait_ph3_idle();
    int t;
    t = 0;
    do begin @(negedge CLK12); t++; end while (!(CE && !CQ && !BUSY) && t < 16);
    if (t >= 16) chk("ph3_timeout", 0, 1);
  endtask

  task automatic start_txn(input bit rw, input logic [15:0] a, input logic [7:0] wd,
                           input logic [7:0] din_v, input int hold, input bit align);
    int t;
    if (align) wait_ph3_idle();
    @(posedge CLK12); #1;
    hold_cfg = hold; DIN = din_v; REQ_RW = rw; REQ_ADDR = a; REQ_WDATA = wd; REQ = 1'b1;
    req_cyc = cyc;
    t = 0;
    do begin @(negedge CLK12); t++; end while (!REQ_ACK && t < 16);
    if (!REQ_ACK) chk("ack_timeout", 0, 1);
    @(posedge CLK12); #1;
    REQ = 1'b0; REQ_RW = 1'($urandom); REQ_ADDR = 16'($urandom); REQ_WDATA = 8'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin @(negedge CLK12); t++; end while (!DONE && t < 1100);
    if (!DONE) chk("done_timeout", 0, 1);
    #1;
  endtask

  task automatic do_txn(input bit rw, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] din_v, input int hold, input bit align);
    start_txn(rw, a, wd, din_v, hold, align);
    wait_done();
  endtask

  task automatic chk_reset_literals();
    chk("async_as", AS, 0);     chk("async_addr", ADDR, 0); chk("async_rwb", RWb, 1);
    chk("async_doe", DOE, 0);   chk("async_dout", DOUT, 0); chk("async_done", DONE, 0);
    chk("async_busy", BUSY, 0); chk("async_ack", REQ_ACK, 0);
    chk("async_ce", CE, 0);     chk("async_cq", CQ, 0);
    chk("async_err", ERR, 0);   chk("async_rdata", RDATA, 0);
  endtask

  initial begin : stimulus
    int t, n0, d0;
    repeat (3) @(posedge CLK12);
    #1 chk_reset_literals();
    RSTn = 1'b1;

    // Read, immediate DTAC.
    do_txn(1'b1, 16'h5A00, 8'h00, 8'h3C, 0, 1'b0);
    $display("read 5A00: lat=%0d as=%0d rdata=%0h err=%0b", done_cyc - ack_cyc, as_cnt, RDATA, ERR);
    chk("rd_lat", done_cyc - ack_cyc, 5); chk("rd_as_cnt", as_cnt, 3);
    chk("rd_data", RDATA, 8'h3C);         chk("rd_err", ERR, 0);

    // Write with three stretched T3 samples.
    do_txn(1'b0, 16'h7C10, 8'hA5, 8'h00, 3, 1'b0);
    $display("write 7C10: lat=%0d t3=%0d err=%0b", done_cyc - ack_cyc, t3_cnt, ERR);
    chk("wr_lat", done_cyc - ack_cyc, 8); chk("wr_t3_cnt", t3_cnt, 4);
    chk("wr_err", ERR, 0);                chk("wr_rdata_kept", RDATA, 8'h3C);

    // Read timeout with DTAC stuck high.
    do_txn(1'b1, 16'h1234, 8'h00, 8'h55, 1000, 1'b0);
    $display("read timeout: lat=%0d rdata=%0h err=%0b", done_cyc - ack_cyc, RDATA, ERR);
    chk("to_lat", done_cyc - ack_cyc, 9); chk("to_err", ERR, 1); chk("to_rdata", RDATA, 8'hFF);

    // DTAC arriving on the very last allowed sample still completes normally.
    do_txn(1'b1, 16'h0042, 8'h00, 8'h66, 4, 1'b0);
    $display("read edge: lat=%0d rdata=%0h err=%0b", done_cyc - ack_cyc, RDATA, ERR);
    chk("edge_lat", done_cyc - ack_cyc, 9); chk("edge_err", ERR, 0); chk("edge_rdata", RDATA, 8'h66);

    // Write timeout leaves RDATA alone.
    do_txn(1'b0, 16'h0F0F, 8'h11, 8'h77, 50, 1'b0);
    $display("write timeout: err=%0b rdata=%0h", ERR, RDATA);
    chk("wto_err", ERR, 1); chk("wto_rdata", RDATA, 8'h66);

    // A one-cycle REQ at PH0 is withdrawn before PH3: no transaction.
    n0 = n_ack;
    wait_ph3_idle();
    @(posedge CLK12); #1 REQ = 1'b1;
    @(posedge CLK12); #1 REQ = 1'b0;
    repeat (6) @(posedge CLK12);
    #1 $display("withdrawn req: acks=%0d", n_ack - n0);
    chk("withdrawn_no_ack", n_ack - n0, 0);

    // Request raised at PH0 is acknowledged three cycles later.
    do_txn(1'b1, 16'h2468, 8'h00, 8'h9A, 1, 1'b1);
    $display("aligned read: ack_delay=%0d rdata=%0h", ack_cyc - req_cyc, RDATA);
    chk("align_delay", ack_cyc - req_cyc, 3); chk("align_rdata", RDATA, 8'h9A);

    // Back-to-back: REQ held across two transactions.
    @(posedge CLK12); #1;
    hold_cfg = 0; DIN = 8'h5E; REQ_RW = 1'b1; REQ_ADDR = 16'hC000; REQ = 1'b1;
    n0 = n_ack; t = 0;
    while (n_ack - n0 < 2 && t < 40) begin @(negedge CLK12); #1 t++; end
    @(posedge CLK12); #1 REQ = 1'b0;
    $display("back-to-back: ack_gap=%0d done1_off=%0d", ack_cyc - prev_ack_cyc, done_cyc - prev_ack_cyc);
    chk("b2b_acks", n_ack - n0, 2);
    chk("b2b_gap", ack_cyc - prev_ack_cyc, 8);
    chk("b2b_done1", done_cyc - prev_ack_cyc, 5);
    wait_done();
    chk("b2b_rdata", RDATA, 8'h5E);

    // Reset asserted in the middle of a T3 stretch.
    d0 = n_done;
    start_txn(1'b1, 16'hFACE, 8'h00, 8'h12, 1000, 1'b0);
    t = 0;
    while (t3_cnt < 2 && t < 20) begin @(negedge CLK12); #1 t++; end
    chk("stretch_seen", (t3_cnt >= 2), 1);
    #2 RSTn = 1'b0;
    #1 chk_reset_literals();
    $display("reset mid-stretch: as=%0b busy=%0b ce=%0b", AS, BUSY, CE);
    repeat (2) @(posedge CLK12);
    #1 RSTn = 1'b1;
    chk("rst_no_done", n_done - d0, 0);
    do_txn(1'b1, 16'hBEEF, 8'h00, 8'hC3, 0, 1'b0);
    $display("read after reset: lat=%0d rdata=%0h err=%0b", done_cyc - ack_cyc, RDATA, ERR);
    chk("post_rst_lat", done_cyc - ack_cyc, 5); chk("post_rst_rdata", RDATA, 8'hC3);
    chk("post_rst_err", ERR, 0);

    repeat (4) @(posedge CLK12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
